// File: rtl/hazard_ctrl.sv
// Decode-stage hazard and forwarding controller with a shadow pipeline of in-flight writers.
// Define HAZ_FWD_BYPASS_EN to enable forwarding; otherwise the unit is a pure interlock.
module hazard_ctrl #(
  parameter int unsigned REG_WORDS  = 32,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned ALU_READY  = 0,
  parameter int unsigned LOAD_READY = 1,
  parameter bit          REG0_ZERO  = 1'b1,
  parameter int unsigned CNT_BITS   = 16,
  localparam int unsigned AW = $clog2(REG_WORDS),
  localparam int unsigned SW = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                id_valid,
  input  logic [AW-1:0]       r1_addr,
  input  logic [AW-1:0]       r2_addr,
  input  logic                r1_used,
  input  logic                r2_used,
  input  logic [AW-1:0]       waddr,
  input  logic                rw_,
  input  logic                sel_mem,
  input  logic                flush,
  output logic                stall,
  output logic                bubble,
  output logic [SW-1:0]       fwd1_sel,
  output logic [SW-1:0]       fwd2_sel,
  output logic [CNT_BITS-1:0] stall_cnt
);

`ifdef HAZ_FWD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Shadow pipeline: index 0 is EX, higher indices are older stages.
  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_wr;
  logic [DEPTH-1:0] e_load;
  logic [AW-1:0]    e_waddr [DEPTH];

  logic [AW-1:0] src [2];
  logic [1:0]    used;
  logic [1:0]    hit;
  logic [1:0]    win_load;
  logic [1:0]    ready;
  logic [1:0]    not_ready;
  logic [SW-1:0] win_idx [2];
  logic [SW-1:0] fwd [2];
  logic          take;

  assign src[0] = r1_addr;
  assign src[1] = r2_addr;
  assign used   = {r2_used, r1_used};

  // Youngest matching writer per operand: scan oldest to youngest so the lowest index wins.
  always_comb begin
    hit      = '0;
    win_load = '0;
    win_idx[0] = '0;
    win_idx[1] = '0;
    for (int op = 0; op < 2; op++) begin
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        if (used[op] && id_valid && e_valid[k] && e_wr[k] &&
            (e_waddr[k] == src[op]) && !(REG0_ZERO && (src[op] == '0))) begin
          hit[op]      = 1'b1;
          win_idx[op]  = SW'(k);
          win_load[op] = e_load[k];
        end
      end
    end
  end

  // Latency check; without bypass every match interlocks until the producer leaves the window.
  always_comb begin
    ready     = '0;
    not_ready = '0;
    fwd[0]    = '0;
    fwd[1]    = '0;
    for (int op = 0; op < 2; op++) begin
      ready[op]     = 32'(win_idx[op]) >= (win_load[op] ? LOAD_READY : ALU_READY);
      not_ready[op] = hit[op] && (!BYPASS || !ready[op]);
      if (hit[op] && BYPASS && ready[op]) begin
        fwd[op] = win_idx[op] + SW'(1);
      end
    end
  end

  assign stall    = !flush && (|not_ready);
  assign fwd1_sel = fwd[0];
  assign fwd2_sel = fwd[1];
  assign take     = id_valid && !stall && !flush;

  // Shift the shadow pipeline; a stalled, flushed or empty decode slot enters as a bubble.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      e_valid   <= '0;
      e_wr      <= '0;
      e_load    <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        e_waddr[k] <= '0;
      end
      bubble    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      for (int k = int'(DEPTH) - 1; k > 0; k--) begin
        e_valid[k] <= e_valid[k-1];
        e_wr[k]    <= e_wr[k-1];
        e_load[k]  <= e_load[k-1];
        e_waddr[k] <= e_waddr[k-1];
      end
      e_valid[0] <= take;
      e_wr[0]    <= take && !rw_;
      e_load[0]  <= take && sel_mem;
      e_waddr[0] <= take ? waddr : '0;
      bubble     <= !take;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_BITS'(1);
      end
    end
  end

endmodule
